// File: rtl/iter_muldiv_unit_if.sv
// Start/done handshake and result bus between the ARM controller and the
// iterative multiply/divide coprocessor.
interface iter_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags, dbz
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Iterative MUL/UMULL/UDIV/SDIV coprocessor: one bit per RUN cycle, sign and
// corner-case fixup in FIX, results and NZCV flags registered into DONE.
module iter_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    iter_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]       OP_UMULL = 2'b01;
    localparam logic [1:0]       OP_SDIV  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             primed;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_dbz;
    logic             fin_ovf;
    logic             fin_n;
    logic             fin_z;

    // A remainder below the divisor keeps the accepted difference under
    // 2^WIDTH, so the subtraction can drop the top bit of the trial value.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_sub   = div_shift[WIDTH-1:0] - b_mag;

    always_comb begin
        fin_lo  = prod[WIDTH-1:0];
        fin_hi  = prod[2*WIDTH-1:WIDTH];
        fin_dbz = 1'b0;
        fin_ovf = 1'b0;
        if (op_q[1]) begin
            if (b_raw == '0) begin
                fin_lo  = '0;
                fin_hi  = a_raw;
                fin_dbz = 1'b1;
            end else begin
                fin_lo  = neg_q ? -quo : quo;
                fin_hi  = (op_q[0] && a_raw[WIDTH-1]) ? -rem : rem;
                fin_ovf = (op_q == OP_SDIV) && (a_raw == MOST_NEG) && (b_raw == '1);
            end
        end
        if (op_q == OP_UMULL) begin
            fin_n = fin_hi[WIDTH-1];
            fin_z = ({fin_hi, fin_lo} == '0);
        end else begin
            fin_n = fin_lo[WIDTH-1];
            fin_z = (fin_lo == '0);
        end
    end

    // The first RUN cycle loads the shift registers; WIDTH iterations follow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            primed        <= 1'b0;
            op_q          <= '0;
            a_raw         <= '0;
            b_raw         <= '0;
            a_mag         <= '0;
            b_mag         <= '0;
            neg_q         <= 1'b0;
            prod          <= '0;
            rem           <= '0;
            quo           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result_lo <= '0;
            bus.result_hi <= '0;
            bus.flags     <= '0;
            bus.dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        primed   <= 1'b0;
                        op_q     <= bus.op;
                        a_raw    <= bus.a;
                        b_raw    <= bus.b;
                        a_mag    <= (bus.op == OP_SDIV && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        b_mag    <= (bus.op == OP_SDIV && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        neg_q    <= (bus.op == OP_SDIV) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!primed) begin
                        primed <= 1'b1;
                        prod   <= {{WIDTH{1'b0}}, b_mag};
                        rem    <= '0;
                        quo    <= a_mag;
                    end else begin
                        if (op_q[1]) begin
                            rem <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], div_ge};
                        end else begin
                            prod <= {mul_sum, prod[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state         <= DONE;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.result_lo <= fin_lo;
                    bus.result_hi <= fin_hi;
                    bus.flags     <= {fin_n, fin_z, 1'b0, fin_ovf};
                    bus.dbz       <= fin_dbz;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed-vector bench: stimulus pushes expected results, monitors pop and
// compare on each done pulse (32-bit unit plus an 8-bit instance).
module tb_iter_muldiv_unit;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  flags;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  flags;
        logic        dbz;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;
    exp_t exp_q[$];
    exp_t exp8_q[$];
    vec_t vecs[$];

    iter_muldiv_unit_if #(.WIDTH(32)) bus ();
    iter_muldiv_unit_if #(.WIDTH(8))  bus8 ();

    iter_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    iter_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard side for the 32-bit unit.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("result_lo", bus.result_lo, e.lo);
                checkOutput("result_hi", bus.result_hi, e.hi);
                checkOutput("flags", bus.flags, e.flags);
                checkOutput("dbz", bus.dbz, e.dbz);
                checkOutput("latency", cyc - e.acc, 34);
                checkOutput("busy_with_done", bus.busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && bus8.done) begin
            exp_t e;
            if (exp8_q.size() == 0) begin
                checkOutput("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e = exp8_q.pop_front();
                checkOutput("result_lo8", bus8.result_lo, e.lo);
                checkOutput("result_hi8", bus8.result_hi, e.hi);
                checkOutput("flags8", bus8.flags, e.flags);
                checkOutput("latency8", cyc - e.acc, 10);
            end
        end
    end

    task automatic waitDone(input bit narrow, input int min_busy);
        int run = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (narrow ? bus8.done : bus.done) seen = 1'b1;
            else if (narrow ? bus8.busy : bus.busy) run++;
            else run = 0;
        end
        if (!seen) checkOutput(narrow ? "done8_timeout" : "done_timeout", 64'd0, 64'd1);
        else if (min_busy > 0) checkOutput("busy_before_done", 64'(run >= min_busy), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        @(posedge clk);
        #1;
        exp_q.push_back('{lo: v.lo, hi: v.hi, flags: v.flags, dbz: v.dbz, acc: cyc});
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        waitDone(1'b0, 33);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dc;
        bus.start  = 1'b0;
        bus.op     = OP_MUL;
        bus.a      = '0;
        bus.b      = '0;
        bus8.start = 1'b0;
        bus8.op    = OP_MUL;
        bus8.a     = '0;
        bus8.b     = '0;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_lo", bus.result_lo, 0);
        checkOutput("rst_hi", bus.result_hi, 0);
        checkOutput("rst_flags", bus.flags, 0);
        checkOutput("rst_dbz", bus.dbz, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        reset = 1'b1;

        vecs.push_back('{OP_MUL,   32'd7,          32'd6,          32'd42,         32'd0,          4'b0000, 1'b0});
        vecs.push_back('{OP_UMULL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  4'b1000, 1'b0});
        vecs.push_back('{OP_MUL,   32'h0001_0000,  32'h0001_0000,  32'h0,          32'h1,          4'b0100, 1'b0});
        vecs.push_back('{OP_UMULL, 32'h0001_0000,  32'h0001_0000,  32'h0,          32'h1,          4'b0000, 1'b0});
        vecs.push_back('{OP_UDIV,  32'd100,        32'd7,          32'd14,         32'd2,          4'b0000, 1'b0});
        vecs.push_back('{OP_SDIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000, 1'b0});
        vecs.push_back('{OP_SDIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          4'b1000, 1'b0});
        vecs.push_back('{OP_SDIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  4'b0000, 1'b0});
        vecs.push_back('{OP_UDIV,  32'd5,          32'd0,          32'd0,          32'd5,          4'b0100, 1'b1});
        vecs.push_back('{OP_UDIV,  32'd9,          32'd3,          32'd3,          32'd0,          4'b0000, 1'b0});
        vecs.push_back('{OP_SDIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          4'b1001, 1'b0});
        foreach (vecs[i]) applyStimulus(vecs[i]);

        repeat (5) @(negedge clk);
        checkOutput("hold_lo", bus.result_lo, 32'h8000_0000);
        checkOutput("hold_flags", bus.flags, 4'b1001);

        // start pulsed mid-operation must be dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd11;
        bus.b     = 32'd13;
        @(posedge clk);
        #1;
        exp_q.push_back('{lo: 32'd143, hi: 32'd0, flags: 4'b0000, dbz: 1'b0, acc: cyc});
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_UDIV;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(1'b0, 0);
        @(negedge clk);
        dc = done_count;
        repeat (40) @(negedge clk);
        checkOutput("no_extra_done", done_count, dc);
        checkOutput("idle_busy", bus.busy, 0);

        // start held through DONE relaunches with the inputs present then
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(posedge clk);
        #1;
        exp_q.push_back('{lo: 32'd15, hi: 32'd0, flags: 4'b0000, dbz: 1'b0, acc: cyc});
        bus.op = OP_UDIV;
        bus.a  = 32'd50;
        bus.b  = 32'd5;
        waitDone(1'b0, 33);
        @(posedge clk);
        #1;
        exp_q.push_back('{lo: 32'd10, hi: 32'd0, flags: 4'b0000, dbz: 1'b0, acc: cyc});
        bus.start = 1'b0;
        waitDone(1'b0, 33);

        // asynchronous abort in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_UMULL;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_lo", bus.result_lo, 0);
        checkOutput("abort_hi", bus.result_hi, 0);
        checkOutput("abort_flags", bus.flags, 0);
        checkOutput("abort_dbz", bus.dbz, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        dc = done_count;
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("abort_no_done", done_count, dc);
        checkOutput("abort_idle", bus.busy, 0);

        // narrow instance
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = OP_UDIV;
        bus8.a     = 8'd200;
        bus8.b     = 8'd3;
        @(posedge clk);
        #1;
        exp8_q.push_back('{lo: 32'd66, hi: 32'd2, flags: 4'b0000, dbz: 1'b0, acc: cyc});
        bus8.start = 1'b0;
        waitDone(1'b1, 9);

        repeat (5) @(negedge clk);
        checkOutput("pending32", exp_q.size(), 0);
        checkOutput("pending8", exp8_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
